// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: states, instruction classes,
// datapath select codes and the opcode/funct constants the decoder matches on.
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_ADDR,
    S_MEM_RD, S_MEM_WR, S_WB_MEM, S_BRANCH, S_JUMP, S_ERR
  } state_e;

  typedef enum logic [3:0] {
    CLS_R, CLS_ADDIU, CLS_ORI, CLS_LUI, CLS_LW, CLS_SW, CLS_BEQ, CLS_J, CLS_ILL
  } cls_e;

  localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_AND = 3'd2,
                         ALU_OR  = 3'd3, ALU_SLT = 3'd4, ALU_PASSB = 3'd5;
  localparam logic [1:0] EXT_ZERO = 2'd0, EXT_LUI = 2'd1, EXT_SIGN = 2'd2;
  localparam logic [1:0] ALUSRCB_RT = 2'd0, ALUSRCB_FOUR = 2'd1,
                         ALUSRCB_EXT = 2'd2, ALUSRCB_EXT_SH2 = 2'd3;
  localparam logic [1:0] PCSRC_ALU = 2'd0, PCSRC_ALUOUT = 2'd1, PCSRC_JUMP = 2'd2;

  localparam logic [5:0] OP_RTYPE = 6'h00, OP_ADDIU = 6'h09, OP_ORI = 6'h0d,
                         OP_LUI   = 6'h0f, OP_LW    = 6'h23, OP_SW  = 6'h2b,
                         OP_BEQ   = 6'h04, OP_J     = 6'h02;
  localparam logic [5:0] F_ADDU = 6'h21, F_SUBU = 6'h23, F_AND = 6'h24,
                         F_OR   = 6'h25, F_SLT  = 6'h2a;

  typedef struct packed {
    cls_e       cls;
    logic [2:0] alu_op;
    logic [1:0] ext_op;
    logic       illegal;
  } dec_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and handshakes in,
// every datapath select and strobe out.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       ir_write;
  logic       mem_read;
  logic       mem_write;
  logic       iord;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic [1:0] pc_src;
  logic [1:0] ext_op;
  logic       fault;
  logic       busy;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_src, ext_op, fault, busy
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  pc_write, pc_write_cond, ir_write, mem_read, mem_write, iord,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
           pc_src, ext_op, fault, busy
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational instruction classifier: {opcode, funct} -> class plus the
// ALU operation and extender mode the execute stage will need.
module multicycle_ctrl_decode
  import multicycle_ctrl_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output dec_t       o_dec
);

  always_comb begin
    o_dec = '{cls: CLS_ILL, alu_op: ALU_ADD, ext_op: EXT_ZERO, illegal: 1'b1};
    case (i_opcode)
      OP_RTYPE: begin
        o_dec.cls     = CLS_R;
        o_dec.illegal = 1'b0;
        case (i_funct)
          F_ADDU:  o_dec.alu_op = ALU_ADD;
          F_SUBU:  o_dec.alu_op = ALU_SUB;
          F_AND:   o_dec.alu_op = ALU_AND;
          F_OR:    o_dec.alu_op = ALU_OR;
          F_SLT:   o_dec.alu_op = ALU_SLT;
          default: begin
            o_dec.cls     = CLS_ILL;
            o_dec.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDIU: o_dec = '{cls: CLS_ADDIU, alu_op: ALU_ADD,   ext_op: EXT_SIGN, illegal: 1'b0};
      OP_ORI:   o_dec = '{cls: CLS_ORI,   alu_op: ALU_OR,    ext_op: EXT_ZERO, illegal: 1'b0};
      OP_LUI:   o_dec = '{cls: CLS_LUI,   alu_op: ALU_PASSB, ext_op: EXT_LUI,  illegal: 1'b0};
      OP_LW:    o_dec = '{cls: CLS_LW,    alu_op: ALU_ADD,   ext_op: EXT_SIGN, illegal: 1'b0};
      OP_SW:    o_dec = '{cls: CLS_SW,    alu_op: ALU_ADD,   ext_op: EXT_SIGN, illegal: 1'b0};
      OP_BEQ:   o_dec = '{cls: CLS_BEQ,   alu_op: ALU_SUB,   ext_op: EXT_SIGN, illegal: 1'b0};
      OP_J:     o_dec = '{cls: CLS_J,     alu_op: ALU_ADD,   ext_op: EXT_ZERO, illegal: 1'b0};
      default:  ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready and traps illegal opcodes and memory timeouts.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic             clk,
  input  logic             rst,
  multicycle_ctrl_if.master bus
);

  state_e          r_state, w_next;
  dec_t            w_dec;
  cls_e            r_cls;
  logic [2:0]      r_alu_op;
  logic [1:0]      r_ext_op;
  logic [TO_W-1:0] r_to;
  logic            w_mem_st, w_to_hit;

  multicycle_ctrl_decode u_dec (
    .i_opcode (bus.opcode),
    .i_funct  (bus.funct),
    .o_dec    (w_dec)
  );

  assign w_mem_st = (r_state == S_FETCH) || (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  // A ready on the limit cycle still completes the access.
  assign w_to_hit = w_mem_st && !bus.mem_ready && (r_to == TO_W'(MEM_TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst || (w_next != r_state)) r_to <= '0;
    else if (w_mem_st && !bus.mem_ready) r_to <= r_to + 1'b1;
  end

  // Class and execute controls are captured once so later states never look at opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cls    <= CLS_ILL;
      r_alu_op <= ALU_ADD;
      r_ext_op <= EXT_ZERO;
    end else if (r_state == S_DECODE) begin
      r_cls    <= w_dec.cls;
      r_alu_op <= w_dec.alu_op;
      r_ext_op <= w_dec.ext_op;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  if (bus.mem_ready) w_next = S_DECODE; else if (w_to_hit) w_next = S_ERR;
      S_DECODE: begin
        if (w_dec.illegal) w_next = S_ERR;
        else case (w_dec.cls)
          CLS_R:                        w_next = S_EXEC_R;
          CLS_ADDIU, CLS_ORI, CLS_LUI:  w_next = S_EXEC_I;
          CLS_LW, CLS_SW:               w_next = S_ADDR;
          CLS_BEQ:                      w_next = S_BRANCH;
          CLS_J:                        w_next = S_JUMP;
          default:                      w_next = S_ERR;
        endcase
      end
      S_EXEC_R, S_EXEC_I: w_next = S_WB_ALU;
      S_ADDR:   w_next = (r_cls == CLS_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: if (bus.mem_ready) w_next = S_WB_MEM; else if (w_to_hit) w_next = S_ERR;
      S_MEM_WR: if (bus.mem_ready) w_next = S_FETCH;  else if (w_to_hit) w_next = S_ERR;
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: w_next = S_FETCH;
      S_ERR:    w_next = S_ERR;
      default:  w_next = S_ERR;
    endcase
  end

  always_comb begin
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.iord          = 1'b0;
    bus.reg_write     = 1'b0;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = ALUSRCB_RT;
    bus.alu_op        = ALU_ADD;
    bus.pc_src        = PCSRC_ALU;
    bus.ext_op        = EXT_ZERO;
    bus.fault         = (r_state == S_ERR);
    bus.busy          = (r_state != S_IDLE) && (r_state != S_ERR);
    case (r_state)
      S_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = ALUSRCB_FOUR;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        bus.alu_src_b = ALUSRCB_EXT_SH2;
        bus.ext_op    = EXT_SIGN;
      end
      S_EXEC_R: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = r_alu_op;
      end
      S_EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ALUSRCB_EXT;
        bus.alu_op    = r_alu_op;
        bus.ext_op    = r_ext_op;
      end
      S_WB_ALU: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = (r_cls == CLS_R);
      end
      S_ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = ALUSRCB_EXT;
        bus.ext_op    = EXT_SIGN;
      end
      S_MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.iord     = 1'b1;
      end
      S_MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.iord      = 1'b1;
      end
      S_WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_op        = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: a per-instruction phase model expands each
// instruction and its memory wait pattern into the expected cycle-by-cycle outputs.
module tb_multicycle_ctrl;

  localparam int LIMIT = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(LIMIT), .TO_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef enum {P_IDLE, P_FETCH, P_DECODE, P_EXEC_R, P_EXEC_I, P_WB_ALU, P_ADDR,
                P_MEM_RD, P_MEM_WR, P_WB_MEM, P_BRANCH, P_JUMP, P_ERR} ph_e;

  typedef struct packed {
    logic pcw, pcwc, irw, mrd, mwr, iord, rw, rdst, m2r, srca;
    logic [1:0] srcb;
    logic [2:0] alu;
    logic [1:0] pcsrc;
    logic [1:0] ext;
    logic fault, busy;
  } out_t;

  typedef struct {
    ph_e  ph;
    logic rdy;
  } step_t;

  step_t      seq[$];
  int         errs = 0;
  int         nchk = 0;
  logic [5:0] cur_opc = 6'h00;
  logic [5:0] cur_fn  = 6'h00;
  logic       cur_zero = 1'b0;
  out_t       obs, exp_o;

  logic [5:0] ops[8] = '{6'h00, 6'h09, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02};
  logic [5:0] fns[5] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2a};

  function automatic out_t model_out(ph_e ph, logic rdy, logic [5:0] opc, logic [5:0] fn);
    out_t o = '0;
    case (ph)
      P_FETCH:  begin o.mrd = 1'b1; o.srcb = 2'd1; o.irw = rdy; o.pcw = rdy; end
      P_DECODE: begin o.srcb = 2'd3; o.ext = 2'd2; end
      P_EXEC_R: begin
        o.srca = 1'b1;
        case (fn)
          6'h23:   o.alu = 3'd1;
          6'h24:   o.alu = 3'd2;
          6'h25:   o.alu = 3'd3;
          6'h2a:   o.alu = 3'd4;
          default: o.alu = 3'd0;
        endcase
      end
      P_EXEC_I: begin
        o.srca = 1'b1; o.srcb = 2'd2;
        if (opc == 6'h0f)      begin o.ext = 2'd1; o.alu = 3'd5; end
        else if (opc == 6'h0d) begin o.ext = 2'd0; o.alu = 3'd3; end
        else                   begin o.ext = 2'd2; o.alu = 3'd0; end
      end
      P_WB_ALU: begin o.rw = 1'b1; o.rdst = (opc == 6'h00); end
      P_ADDR:   begin o.srca = 1'b1; o.srcb = 2'd2; o.ext = 2'd2; end
      P_MEM_RD: begin o.mrd = 1'b1; o.iord = 1'b1; end
      P_MEM_WR: begin o.mwr = 1'b1; o.iord = 1'b1; end
      P_WB_MEM: begin o.rw = 1'b1; o.m2r = 1'b1; end
      P_BRANCH: begin o.srca = 1'b1; o.alu = 3'd1; o.pcwc = 1'b1; o.pcsrc = 2'd1; end
      P_JUMP:   begin o.pcw = 1'b1; o.pcsrc = 2'd2; end
      P_ERR:    o.fault = 1'b1;
      default:  ;
    endcase
    o.busy = !(ph inside {P_IDLE, P_ERR});
    return o;
  endfunction

  function automatic out_t observe();
    out_t o;
    o.pcw = bus.pc_write; o.pcwc = bus.pc_write_cond; o.irw = bus.ir_write;
    o.mrd = bus.mem_read; o.mwr = bus.mem_write; o.iord = bus.iord;
    o.rw = bus.reg_write; o.rdst = bus.reg_dst; o.m2r = bus.mem_to_reg;
    o.srca = bus.alu_src_a; o.srcb = bus.alu_src_b; o.alu = bus.alu_op;
    o.pcsrc = bus.pc_src; o.ext = bus.ext_op; o.fault = bus.fault; o.busy = bus.busy;
    return o;
  endfunction

  // Memory-state phase: w wait cycles then ready, or timeout once LIMIT is reached unserved.
  task automatic push_wait(input ph_e ph, input int w, output bit to);
    to = 1'b0;
    for (int k = 0; k <= LIMIT; k++) begin
      if (k == w) begin seq.push_back('{ph, 1'b1}); return; end
      seq.push_back('{ph, 1'b0});
      if (k == LIMIT) begin seq.push_back('{P_ERR, 1'b0}); to = 1'b1; return; end
    end
  endtask

  task automatic push_any(input ph_e ph);
    seq.push_back('{ph, 1'($urandom)});
  endtask

  task automatic build(input logic [5:0] opc, input logic [5:0] fn, input int wf, input int wm);
    bit to;
    seq.delete();
    cur_opc = opc;
    cur_fn  = fn;
    push_wait(P_FETCH, wf, to);
    if (to) return;
    push_any(P_DECODE);
    case (opc)
      6'h00: begin
        if (fn inside {6'h21, 6'h23, 6'h24, 6'h25, 6'h2a}) begin
          push_any(P_EXEC_R); push_any(P_WB_ALU);
        end else push_any(P_ERR);
      end
      6'h09, 6'h0d, 6'h0f: begin push_any(P_EXEC_I); push_any(P_WB_ALU); end
      6'h23: begin push_any(P_ADDR); push_wait(P_MEM_RD, wm, to); if (!to) push_any(P_WB_MEM); end
      6'h2b: begin push_any(P_ADDR); push_wait(P_MEM_WR, wm, to); end
      6'h04: push_any(P_BRANCH);
      6'h02: push_any(P_JUMP);
      default: push_any(P_ERR);
    endcase
  endtask

  // Drive one cycle's inputs at the falling edge, sample the outputs 1 ns later.
  task automatic step(input step_t s, output out_t o);
    @(negedge clk);
    bus.mem_ready = s.rdy;
    bus.opcode    = (s.ph == P_FETCH) ? 6'($urandom) : cur_opc;
    bus.funct     = (s.ph == P_FETCH) ? 6'($urandom) : cur_fn;
    bus.zero      = (s.ph == P_BRANCH) ? cur_zero : 1'($urandom);
    #1 o = observe();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'($urandom);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b1;
      bus.mem_ready = 1'($urandom);
      bus.opcode = 6'($urandom);
      #1 obs = observe();
      exp_o = model_out(P_IDLE, 1'b0, 6'h00, 6'h00);
      if (i > 0) begin
        nchk++;
        if (obs !== exp_o) begin errs++; $display("FAIL reset cyc%0d: got %h expected %h", i, obs, exp_o); end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_rtype();
    build(6'h00, 6'h21, 0, 0);
    foreach (seq[i]) begin
      step(seq[i], obs);
      exp_o = model_out(seq[i].ph, seq[i].rdy, cur_opc, cur_fn);
      nchk++;
      if (obs !== exp_o) begin errs++; $display("FAIL addu step%0d %s: got %h expected %h", i, seq[i].ph.name(), obs, exp_o); end
    end
    foreach (fns[f]) begin
      build(6'h00, fns[f], $urandom_range(0, 2), 0);
      foreach (seq[i]) begin
        step(seq[i], obs);
        exp_o = model_out(seq[i].ph, seq[i].rdy, cur_opc, cur_fn);
        nchk++;
        if (obs !== exp_o) begin errs++; $display("FAIL rtype fn=%h step%0d %s: got %h expected %h", fns[f], i, seq[i].ph.name(), obs, exp_o); end
      end
    end
  endtask

  task automatic test_itype();
    logic [5:0] iops[3] = '{6'h0f, 6'h0d, 6'h09};
    foreach (iops[n]) begin
      build(iops[n], 6'($urandom), $urandom_range(0, 2), 0);
      foreach (seq[i]) begin
        step(seq[i], obs);
        exp_o = model_out(seq[i].ph, seq[i].rdy, cur_opc, cur_fn);
        nchk++;
        if (obs !== exp_o) begin errs++; $display("FAIL itype op=%h step%0d %s: got %h expected %h", iops[n], i, seq[i].ph.name(), obs, exp_o); end
      end
    end
  endtask

  task automatic test_mem();
    build(6'h23, 6'($urandom), 0, 3);
    nchk++;
    if (seq.size() != 8) begin errs++; $display("FAIL lw_len: model %0d cycles, required 8", seq.size()); end
    foreach (seq[i]) begin
      step(seq[i], obs);
      exp_o = model_out(seq[i].ph, seq[i].rdy, cur_opc, cur_fn);
      nchk++;
      if (obs !== exp_o) begin errs++; $display("FAIL lw_wait step%0d %s: got %h expected %h", i, seq[i].ph.name(), obs, exp_o); end
    end
    build(6'h2b, 6'($urandom), 1, 2);
    foreach (seq[i]) begin
      step(seq[i], obs);
      exp_o = model_out(seq[i].ph, seq[i].rdy, cur_opc, cur_fn);
      nchk++;
      if (obs !== exp_o) begin errs++; $display("FAIL sw_wait step%0d %s: got %h expected %h", i, seq[i].ph.name(), obs, exp_o); end
    end
  endtask

  task automatic test_branch_jump();
    cur_zero = 1'b1;
    build(6'h04, 6'($urandom), 0, 0);
    foreach (seq[i]) begin
      step(seq[i], obs);
      exp_o = model_out(seq[i].ph, seq[i].rdy, cur_opc, cur_fn);
      nchk++;
      if (obs !== exp_o) begin errs++; $display("FAIL beq step%0d %s: got %h expected %h", i, seq[i].ph.name(), obs, exp_o); end
    end
    build(6'h02, 6'($urandom), 0, 0);
    foreach (seq[i]) begin
      step(seq[i], obs);
      exp_o = model_out(seq[i].ph, seq[i].rdy, cur_opc, cur_fn);
      nchk++;
      if (obs !== exp_o) begin errs++; $display("FAIL j step%0d %s: got %h expected %h", i, seq[i].ph.name(), obs, exp_o); end
    end
  endtask

  task automatic test_fetch_limit();
    // Ready arriving exactly on the limit cycle must still succeed.
    build(6'h00, 6'h25, LIMIT, 0);
    foreach (seq[i]) begin
      step(seq[i], obs);
      exp_o = model_out(seq[i].ph, seq[i].rdy, cur_opc, cur_fn);
      nchk++;
      if (obs !== exp_o) begin errs++; $display("FAIL fetch_limit step%0d %s: got %h expected %h", i, seq[i].ph.name(), obs, exp_o); end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int oi = $urandom_range(0, 7);
      cur_zero = 1'($urandom);
      build(ops[oi], fns[$urandom_range(0, 4)], ($urandom_range(0, 9) == 0) ? LIMIT : $urandom_range(0, 3),
            ($urandom_range(0, 9) == 0) ? LIMIT : $urandom_range(0, 3));
      foreach (seq[i]) begin
        step(seq[i], obs);
        exp_o = model_out(seq[i].ph, seq[i].rdy, cur_opc, cur_fn);
        nchk++;
        if (obs !== exp_o) begin errs++; $display("FAIL random#%0d op=%h step%0d %s: got %h expected %h", n, cur_opc, i, seq[i].ph.name(), obs, exp_o); end
      end
    end
  endtask

  task automatic test_illegal();
    logic [5:0] bad_op[2] = '{6'h3f, 6'h00};
    foreach (bad_op[b]) begin
      build(bad_op[b], 6'h00, 0, 0);
      for (int k = 0; k < 20; k++) push_any(P_ERR);
      foreach (seq[i]) begin
        step(seq[i], obs);
        exp_o = model_out(seq[i].ph, seq[i].rdy, cur_opc, cur_fn);
        nchk++;
        if (obs !== exp_o) begin errs++; $display("FAIL illegal op=%h step%0d %s: got %h expected %h", bad_op[b], i, seq[i].ph.name(), obs, exp_o); end
      end
      apply_reset();
      obs = observe();
      exp_o = model_out(P_IDLE, 1'b0, 6'h00, 6'h00);
      nchk++;
      if (obs !== exp_o) begin errs++; $display("FAIL illegal_rst op=%h: got %h expected %h", bad_op[b], obs, exp_o); end
    end
  endtask

  task automatic test_timeout();
    build(6'h00, 6'h21, LIMIT + 5, 0);
    for (int k = 0; k < 4; k++) push_any(P_ERR);
    foreach (seq[i]) begin
      step(seq[i], obs);
      exp_o = model_out(seq[i].ph, seq[i].rdy, cur_opc, cur_fn);
      nchk++;
      if (obs !== exp_o) begin errs++; $display("FAIL fetch_timeout step%0d %s: got %h expected %h", i, seq[i].ph.name(), obs, exp_o); end
    end
    apply_reset();
    build(6'h23, 6'h00, 0, LIMIT + 1);
    foreach (seq[i]) begin
      step(seq[i], obs);
      exp_o = model_out(seq[i].ph, seq[i].rdy, cur_opc, cur_fn);
      nchk++;
      if (obs !== exp_o) begin errs++; $display("FAIL memrd_timeout step%0d %s: got %h expected %h", i, seq[i].ph.name(), obs, exp_o); end
    end
    apply_reset();
  endtask

  task automatic test_reset_midwait();
    for (int k = 0; k < 6; k++) begin
      step('{P_FETCH, 1'b0}, obs);
      exp_o = model_out(P_FETCH, 1'b0, 6'h00, 6'h00);
      nchk++;
      if (obs !== exp_o) begin errs++; $display("FAIL midwait_fetch cyc%0d: got %h expected %h", k, obs, exp_o); end
    end
    @(negedge clk);
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    #1 obs = observe();
    exp_o = model_out(P_IDLE, 1'b0, 6'h00, 6'h00);
    nchk++;
    if (obs !== exp_o) begin errs++; $display("FAIL midwait_rst: got %h expected %h", obs, exp_o); end
    rst = 1'b0;
    // A fresh full-length wait only completes if the counter restarted from zero.
    build(6'h0f, 6'h00, LIMIT, 0);
    foreach (seq[i]) begin
      step(seq[i], obs);
      exp_o = model_out(seq[i].ph, seq[i].rdy, cur_opc, cur_fn);
      nchk++;
      if (obs !== exp_o) begin errs++; $display("FAIL midwait_after step%0d %s: got %h expected %h", i, seq[i].ph.name(), obs, exp_o); end
    end
  endtask

  initial begin
    bus.opcode = 6'h00;
    bus.funct = 6'h00;
    bus.zero = 1'b0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_rtype();
    test_itype();
    test_mem();
    test_branch_jump();
    test_fetch_limit();
    test_random();
    test_timeout();
    test_illegal();
    test_reset_midwait();
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errs, nchk);
    $fatal(1);
  end

endmodule
